// File: rtl/cor_h_engine_if.sv
// rtl/cor_h_engine_if.sv - scratch-memory port shared by the correlation engine and its memory
interface cor_h_engine_if #(
  parameter int ADDR_W = 12
);
  logic [31:0]       memIn;
  logic [ADDR_W-1:0] memReadAddr;
  logic [ADDR_W-1:0] memWriteAddr;
  logic [31:0]       memOut;
  logic              memWriteEn;

  modport master (
    input  memIn,
    output memReadAddr, memWriteAddr, memOut, memWriteEn
  );

  modport slave (
    output memIn,
    input  memReadAddr, memWriteAddr, memOut, memWriteEn
  );
endinterface

// File: rtl/cor_h_engine.sv
// rtl/cor_h_engine.sv - impulse-response energy, normalisation and saturated lag autocorrelation
module cor_h_engine #(
  parameter int L      = 40,
  parameter int NLAGS  = 40,
  parameter int ADDR_W = 12,
  parameter int H_BASE = 0,
  parameter int R_BASE = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              testMode,
  input  logic [ADDR_W-1:0] testReadAddr,
  input  logic [ADDR_W-1:0] testWriteAddr,
  input  logic [31:0]       testMemOut,
  input  logic              testMemWriteEn,
  cor_h_engine_if.master    mem,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  localparam int CW = $clog2(L + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_NORM, S_SCALE, S_CORR_MAC, S_CORR_WR, S_FINISH
  } state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, lag, pair_idx;
  logic [31:0]        energy;
  logic signed [31:0] acc;
  logic               shr1;
  logic [3:0]         kshift;
  logic signed [15:0] hs [L];

  logic [32:0]        e_mac, c_mac;
  logic [4:0]         e_norm;
  logic signed [15:0] h_new, h_scaled;
  logic [ADDR_W-1:0]  eng_raddr, eng_waddr;
  logic [31:0]        eng_wdata;
  logic               eng_we;

  // Returns {saturated, sat32(a + 2*x*y)}; 0x8000*0x8000 clips before the add.
  function automatic logic [32:0] mac_step(input logic signed [31:0] a,
                                           input logic signed [15:0] x,
                                           input logic signed [15:0] y);
    logic signed [31:0] ex, ey, p;
    logic [32:0]        s;
    logic               sat_p, sat_s;
    logic [31:0]        res;
    ex    = x;
    ey    = y;
    sat_p = (x == 16'sh8000) && (y == 16'sh8000);
    p     = sat_p ? 32'sh7FFF_FFFF : ((ex * ey) <<< 1);
    s     = {a[31], a} + {p[31], p};
    sat_s = (s[32] != s[31]);
    if (sat_s) res = s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else       res = s[31:0];
    return {sat_p | sat_s, res};
  endfunction

  function automatic logic signed [15:0] shl_sat(input logic signed [15:0] x,
                                                  input logic [3:0] k);
    logic signed [31:0] w;
    logic signed [15:0] r;
    w = x;
    w = w <<< k;
    if (w > 32'sd32767)       r = 16'sh7FFF;
    else if (w < -32'sd32768) r = 16'sh8000;
    else                      r = w[15:0];
    return r;
  endfunction

  function automatic logic [4:0] norm_l(input logic [31:0] x);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i <= 30; i++) begin
      if (x[i]) n = 5'(30 - i);
    end
    return n;
  endfunction

  always_comb begin
    h_new    = mem.memIn[15:0];
    e_mac    = mac_step(energy, h_new, h_new);
    pair_idx = cnt + lag;
    c_mac    = mac_step(acc, hs[cnt], hs[pair_idx]);
    e_norm   = norm_l(energy);
    h_scaled = shr1 ? (hs[cnt] >>> 1) : shl_sat(hs[cnt], kshift);
  end

  always_comb begin
    state_nx  = state;
    eng_raddr = '0;
    eng_waddr = '0;
    eng_wdata = '0;
    eng_we    = 1'b0;
    busy      = (state != S_IDLE);
    done      = (state == S_FINISH);
    case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: begin
        if (cnt != CW'(L)) eng_raddr = ADDR_W'(H_BASE) + ADDR_W'(cnt);
        else               state_nx  = S_NORM;
      end
      S_NORM:  state_nx = S_SCALE;
      S_SCALE: if (cnt == CW'(L - 1)) state_nx = S_CORR_MAC;
      S_CORR_MAC: if (pair_idx == CW'(L - 1)) state_nx = S_CORR_WR;
      S_CORR_WR: begin
        eng_we    = 1'b1;
        eng_waddr = ADDR_W'(R_BASE) + ADDR_W'(lag);
        eng_wdata = acc;
        state_nx  = (lag == CW'(NLAGS - 1)) ? S_FINISH : S_CORR_MAC;
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lag      <= '0;
      energy   <= '0;
      acc      <= '0;
      shr1     <= 1'b0;
      kshift   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          overflow <= 1'b0;
          energy   <= 32'd1;
          cnt      <= '0;
        end
        S_LOAD: begin
          if (cnt != '0) energy <= e_mac[31:0];
          cnt <= (cnt == CW'(L)) ? '0 : cnt + 1'b1;
        end
        S_NORM: begin
          shr1   <= (energy == 32'h7FFF_FFFF);
          kshift <= e_norm[4:1];
        end
        S_SCALE: begin
          cnt <= (cnt == CW'(L - 1)) ? '0 : cnt + 1'b1;
          lag <= '0;
          acc <= '0;
        end
        S_CORR_MAC: begin
          acc <= c_mac[31:0];
          if (c_mac[32]) overflow <= 1'b1;
          cnt <= cnt + 1'b1;
        end
        S_CORR_WR: begin
          acc <= '0;
          cnt <= '0;
          lag <= lag + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read data lands one cycle after its address, so capture index lags cnt by one.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && cnt != '0) hs[cnt - 1'b1] <= mem.memIn[15:0];
    else if (state == S_SCALE)        hs[cnt]        <= h_scaled;
  end

  assign mem.memReadAddr  = testMode ? testReadAddr   : eng_raddr;
  assign mem.memWriteAddr = testMode ? testWriteAddr  : eng_waddr;
  assign mem.memOut       = testMode ? testMemOut     : eng_wdata;
  assign mem.memWriteEn   = testMode ? testMemWriteEn : eng_we;
endmodule

// File: tb/tb_cor_h_engine.sv
// tb/tb_cor_h_engine.sv - directed self-checking bench for cor_h_engine
module tb_cor_h_engine;
  localparam int L      = 40;
  localparam int NLAGS  = 40;
  localparam int ADDR_W = 12;
  localparam int R_BASE = 64;
  localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              testMode = 1'b0;
  logic [ADDR_W-1:0] testReadAddr = '0;
  logic [ADDR_W-1:0] testWriteAddr = '0;
  logic [31:0]       testMemOut = '0;
  logic              testMemWriteEn = 1'b0;
  logic              busy, done, overflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] smem [0:(1<<ADDR_W)-1];
  logic [15:0] hv  [L];
  logic [31:0] ev  [NLAGS];
  logic [31:0] got [NLAGS];

  cor_h_engine_if #(.ADDR_W(ADDR_W)) mif ();

  cor_h_engine #(
    .L(L), .NLAGS(NLAGS), .ADDR_W(ADDR_W), .H_BASE(0), .R_BASE(R_BASE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .testMode(testMode),
    .testReadAddr(testReadAddr), .testWriteAddr(testWriteAddr),
    .testMemOut(testMemOut), .testMemWriteEn(testMemWriteEn),
    .mem(mif), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mif.memWriteEn) smem[mif.memWriteAddr] <= mif.memOut;
    mif.memIn <= smem[mif.memReadAddr];
  end

  function automatic int exp_latency();
    int s;
    s = (L + 1) + 1 + L + 1;
    for (int k = 0; k < NLAGS; k++) s += L - k + 1;
    return s;
  endfunction

  task automatic clear_vectors();
    for (int n = 0; n < L; n++) hv[n] = 16'h0000;
    for (int k = 0; k < NLAGS; k++) ev[k] = 32'h0000_0000;
  endtask

  task automatic load_h();
    testMode = 1'b1;
    testMemWriteEn = 1'b1;
    for (int n = 0; n < L; n++) begin
      testWriteAddr = ADDR_W'(n);
      testMemOut = {16'hA5A5, hv[n]};
      @(posedge clk); #1;
    end
    for (int k = 0; k < NLAGS; k++) begin
      testWriteAddr = ADDR_W'(R_BASE + k);
      testMemOut = SENTINEL;
      @(posedge clk); #1;
    end
    testMemWriteEn = 1'b0;
    testMode = 1'b0;
  endtask

  task automatic read_r();
    testMode = 1'b1;
    for (int k = 0; k < NLAGS; k++) begin
      testReadAddr = ADDR_W'(R_BASE + k);
      @(posedge clk); #1;
      got[k] = mif.memIn;
    end
    testMode = 1'b0;
  endtask

  // lat counts edges from the start-sampling edge to the edge that samples done.
  task automatic run_engine(output int lat, output int nwr, output bit bad);
    int cyc;
    lat = -1; nwr = 0; bad = 1'b0; cyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (lat < 0 && cyc < 3000) begin
      if (mif.memWriteEn) begin
        nwr++;
        if (mif.memWriteAddr < ADDR_W'(R_BASE) || mif.memWriteAddr >= ADDR_W'(R_BASE + NLAGS)) bad = 1'b1;
      end
      if (done) lat = cyc + 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (mif.memWriteEn !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mif.memWriteEn); end
    checks++; if (mif.memWriteAddr !== '0 || mif.memReadAddr !== '0) begin
      errors++; $display("FAIL reset_addr: got w=%h r=%h expected 0", mif.memWriteAddr, mif.memReadAddr);
    end
    checks++; if (mif.memOut !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", mif.memOut); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_test_mode();
    testMode = 1'b1;
    testMemWriteEn = 1'b1;
    testWriteAddr = ADDR_W'(5);
    testMemOut = 32'h0000_1234;
    testReadAddr = ADDR_W'(7);
    #1;
    checks++; if (mif.memWriteEn !== 1'b1) begin errors++; $display("FAIL tm_we: got %b expected 1", mif.memWriteEn); end
    checks++; if (mif.memWriteAddr !== ADDR_W'(5)) begin errors++; $display("FAIL tm_waddr: got %h expected 005", mif.memWriteAddr); end
    checks++; if (mif.memOut !== 32'h0000_1234) begin errors++; $display("FAIL tm_wdata: got %h expected 00001234", mif.memOut); end
    checks++; if (mif.memReadAddr !== ADDR_W'(7)) begin errors++; $display("FAIL tm_raddr: got %h expected 007", mif.memReadAddr); end
    @(posedge clk); #1;
    testMemWriteEn = 1'b0;
    testReadAddr = ADDR_W'(5);
    @(posedge clk); #1;
    checks++; if (mif.memIn !== 32'h0000_1234) begin errors++; $display("FAIL tm_readback: got %h expected 00001234", mif.memIn); end
    testMode = 1'b0;
    #1;
    checks++; if (mif.memWriteEn !== 1'b0) begin errors++; $display("FAIL tm_release_we: got %b expected 0", mif.memWriteEn); end
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    int lat, nwr;
    bit bad;
    clear_vectors();
    hv[0] = 16'h4000;
    ev[0] = 32'h2000_0000;
    load_h();
    run_engine(lat, nwr, bad);
    checks++; if (lat != exp_latency()) begin errors++; $display("FAIL impulse_latency: got %0d expected %0d", lat, exp_latency()); end
    checks++; if (nwr != NLAGS) begin errors++; $display("FAIL impulse_write_count: got %0d expected %0d", nwr, NLAGS); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL impulse_write_region: got %b expected 0", bad); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL impulse_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
    read_r();
    for (int k = 0; k < NLAGS; k++) begin
      checks++; if (got[k] !== ev[k]) begin errors++; $display("FAIL impulse_r[%0d]: got %h expected %h", k, got[k], ev[k]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL impulse_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_small_impulse();
    int lat, nwr;
    bit bad;
    clear_vectors();
    hv[0] = 16'h0100;
    ev[0] = 32'h2000_0000;
    load_h();
    run_engine(lat, nwr, bad);
    read_r();
    for (int k = 0; k < NLAGS; k++) begin
      checks++; if (got[k] !== ev[k]) begin errors++; $display("FAIL small_r[%0d]: got %h expected %h", k, got[k], ev[k]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL small_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_signed_pair();
    int lat, nwr;
    bit bad;
    clear_vectors();
    hv[0] = 16'h4000;
    hv[1] = 16'hC000;
    ev[0] = 32'h4000_0000;
    ev[1] = 32'hE000_0000;
    load_h();
    run_engine(lat, nwr, bad);
    read_r();
    for (int k = 0; k < NLAGS; k++) begin
      checks++; if (got[k] !== ev[k]) begin errors++; $display("FAIL signed_r[%0d]: got %h expected %h", k, got[k], ev[k]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL signed_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_saturation();
    int lat, nwr;
    bit bad;
    longint v;
    for (int n = 0; n < L; n++) hv[n] = 16'h7FFF;
    for (int k = 0; k < NLAGS; k++) begin
      v = longint'(L - k) * 64'h1FFF_0002;
      ev[k] = (v > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : v[31:0];
    end
    load_h();
    run_engine(lat, nwr, bad);
    read_r();
    for (int k = 0; k < NLAGS; k++) begin
      checks++; if (got[k] !== ev[k]) begin errors++; $display("FAIL sat_r[%0d]: got %h expected %h", k, got[k], ev[k]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow: got %b expected 1", overflow); end
  endtask

  task automatic test_zero();
    int lat, nwr;
    bit bad;
    clear_vectors();
    load_h();
    run_engine(lat, nwr, bad);
    checks++; if (lat != exp_latency()) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", lat, exp_latency()); end
    read_r();
    for (int k = 0; k < NLAGS; k++) begin
      checks++; if (got[k] !== ev[k]) begin errors++; $display("FAIL zero_r[%0d]: got %h expected %h", k, got[k], ev[k]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL zero_overflow_cleared: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_abort();
    int lat, nwr;
    bit bad, stray;
    for (int n = 0; n < L; n++) hv[n] = 16'h7FFF;
    load_h();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL abort_precond: got busy=%b overflow=%b expected 1 1", busy, overflow);
    end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (mif.memWriteEn !== 1'b0) begin errors++; $display("FAIL abort_we: got %b expected 0", mif.memWriteEn); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_overflow: got %b expected 0", overflow); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done || mif.memWriteEn || busy) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL abort_quiet: got activity=%b expected 0", stray); end
    read_r();
    checks++; if (got[0] !== SENTINEL || got[NLAGS-1] !== SENTINEL) begin
      errors++; $display("FAIL abort_no_write: got r0=%h rlast=%h expected %h", got[0], got[NLAGS-1], SENTINEL);
    end
    clear_vectors();
    hv[0] = 16'h4000;
    ev[0] = 32'h2000_0000;
    load_h();
    run_engine(lat, nwr, bad);
    checks++; if (lat != exp_latency()) begin errors++; $display("FAIL restart_latency: got %0d expected %0d", lat, exp_latency()); end
    read_r();
    for (int k = 0; k < NLAGS; k++) begin
      checks++; if (got[k] !== ev[k]) begin errors++; $display("FAIL restart_r[%0d]: got %h expected %h", k, got[k], ev[k]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL restart_overflow: got %b expected 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_test_mode();
    test_impulse();
    test_small_impulse();
    test_signed_pair();
    test_saturation();
    test_zero();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
